// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - ALU opcode encoding consumed by the EX-stage ALU
//   - MIPS primary opcode / R-type funct values recognised by the decoder
//   - operand-select and immediate-extension enums
//   - the issued bundle struct held in the ID/EX register
package alu_pkg;

    localparam int XLEN = 32;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b0001;
    localparam alu_op_t ALU_AND  = 4'b0010;
    localparam alu_op_t ALU_OR   = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_LUI  = 4'b0101;
    localparam alu_op_t ALU_NOR  = 4'b0110;
    localparam alu_op_t ALU_SLL  = 4'b0111;
    localparam alu_op_t ALU_SRL  = 4'b1000;
    localparam alu_op_t ALU_SRA  = 4'b1001;
    localparam alu_op_t ALU_SLLV = 4'b1010;
    localparam alu_op_t ALU_SRLV = 4'b1011;
    localparam alu_op_t ALU_SRAV = 4'b1100;
    localparam alu_op_t ALU_SLT  = 4'b1101;
    localparam alu_op_t ALU_SLTU = 4'b1110;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Operand A source: register, zero-extended immediate (fixed shifts carry
    // shamt in A[10:6]), or constant zero (LUI).
    typedef enum logic [1:0] {
        A_SEL_RS   = 2'd0,
        A_SEL_IMM  = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic {
        B_SEL_RT  = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_t;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_t;

    typedef struct packed {
        alu_op_t         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      dest;
        logic            reg_write;
        logic            illegal;
    } issue_bundle_t;

    function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm, input ext_t mode);
        logic [XLEN-1:0] ext;
        if (mode == EXT_SIGN) begin
            ext = {{(XLEN-16){imm[15]}}, imm};
        end else begin
            ext = {{(XLEN-16){1'b0}}, imm};
        end
        return ext;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake/bus interface of the ALU issue stage.
//   Upstream side : in_valid, in_ready, instr, rs_data, rt_data, flush
//   Downstream side: out_valid, out_ready, alu_op, alu_a, alu_b, dest,
//                    reg_write, illegal
//   modport slave  - the issue stage itself
//   modport master - the surrounding pipeline (decode feeder + EX consumer)
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      dest;
    logic            reg_write;
    logic            illegal;

    modport slave (
        input  in_valid, instr, rs_data, rt_data, flush, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, dest, reg_write, illegal
    );

    modport master (
        output in_valid, instr, rs_data, rt_data, flush, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, dest, reg_write, illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder for the ALU issue stage.
//   instr     in  32  MIPS instruction word
//   op        out 4   ALU opcode (ALU_ADD for unsupported instructions)
//   a_sel     out     operand A source select
//   b_sel     out     operand B source select
//   ext       out     immediate extension mode when b_sel selects the immediate
//   dest      out 5   writeback register (0 for unsupported instructions)
//   reg_write out 1   !illegal && dest != 0
//   illegal   out 1   opcode/funct not supported
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_t     op,
    output a_sel_t      a_sel,
    output b_sel_t      b_sel,
    output ext_t        ext,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_rs_field;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // rs selection happens in the register file; the field itself is not needed here.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        op      = ALU_ADD;
        a_sel   = A_SEL_RS;
        b_sel   = B_SEL_RT;
        ext     = EXT_ZERO;
        dest    = instr[15:11];
        illegal = 1'b0;

        if (opcode == OP_RTYPE) begin
            unique case (funct)
                FN_ADD, FN_ADDU: op = ALU_ADD;
                FN_SUB, FN_SUBU: op = ALU_SUB;
                FN_AND:          op = ALU_AND;
                FN_OR:           op = ALU_OR;
                FN_XOR:          op = ALU_XOR;
                FN_NOR:          op = ALU_NOR;
                FN_SLT:          op = ALU_SLT;
                FN_SLTU:         op = ALU_SLTU;
                FN_SLLV:         op = ALU_SLLV;
                FN_SRLV:         op = ALU_SRLV;
                FN_SRAV:         op = ALU_SRAV;
                // Fixed shifts: the ALU reads shamt from A[10:6], so the low
                // instruction half is passed through zero-extended on A.
                FN_SLL: begin op = ALU_SLL; a_sel = A_SEL_IMM; end
                FN_SRL: begin op = ALU_SRL; a_sel = A_SEL_IMM; end
                FN_SRA: begin op = ALU_SRA; a_sel = A_SEL_IMM; end
                default:         illegal = 1'b1;
            endcase
        end else begin
            dest  = instr[20:16];
            b_sel = B_SEL_IMM;
            unique case (opcode)
                OP_ADDI, OP_ADDIU: begin op = ALU_ADD;  ext = EXT_SIGN; end
                OP_SLTI:           begin op = ALU_SLT;  ext = EXT_SIGN; end
                OP_SLTIU:          begin op = ALU_SLTU; ext = EXT_SIGN; end
                OP_ANDI:           op = ALU_AND;
                OP_ORI:            op = ALU_OR;
                OP_XORI:           op = ALU_XOR;
                OP_LUI:            begin op = ALU_LUI; a_sel = A_SEL_ZERO; end
                default:           illegal = 1'b1;
            endcase
        end

        // Unsupported instructions still issue, but as a harmless ADD of the
        // raw register operands with no destination.
        if (illegal) begin
            op    = ALU_ADD;
            a_sel = A_SEL_RS;
            b_sel = B_SEL_RT;
            ext   = EXT_ZERO;
            dest  = 5'd0;
        end
    end

    assign reg_write = !illegal && (dest != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage producing the ALU input bundle {alu_op, alu_a, alu_b}.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  alu_issue_stage_if.slave
//        upstream  : in_valid/in_ready handshake, instr, rs_data, rt_data, flush
//        downstream: out_valid/out_ready handshake, alu_op, alu_a, alu_b,
//                    dest, reg_write, illegal
// One ID/EX register; a bundle accepted at edge N is presented from edge N+1
// until EX consumes it. flush beats everything and empties the register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter bit RST_NOP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    alu_issue_stage_if.slave    bus
);

    alu_op_t       dec_op;
    a_sel_t        dec_a_sel;
    b_sel_t        dec_b_sel;
    ext_t          dec_ext;
    logic [4:0]    dec_dest;
    logic          dec_reg_write;
    logic          dec_illegal;

    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;

    issue_bundle_t bundle_next;
    issue_bundle_t bundle_reg;
    logic          valid_reg;
    logic          in_ready;

    alu_op_decode u_decode (
        .instr     (bus.instr),
        .op        (dec_op),
        .a_sel     (dec_a_sel),
        .b_sel     (dec_b_sel),
        .ext       (dec_ext),
        .dest      (dec_dest),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

    assign imm_ext = extend_imm(bus.instr[15:0], dec_ext);

    always_comb begin
        a_next = bus.rs_data;
        unique case (dec_a_sel)
            A_SEL_IMM:  a_next = {{(XLEN-16){1'b0}}, bus.instr[15:0]};
            A_SEL_ZERO: a_next = '0;
            default:    a_next = bus.rs_data;
        endcase
    end

    assign b_next = (dec_b_sel == B_SEL_IMM) ? imm_ext : bus.rt_data;

    always_comb begin
        bundle_next           = '0;
        bundle_next.op        = dec_op;
        bundle_next.a         = a_next;
        bundle_next.b         = b_next;
        bundle_next.dest      = dec_dest;
        bundle_next.reg_write = dec_reg_write;
        bundle_next.illegal   = dec_illegal;
    end

    // Depends only on registered state and out_ready, never on in_valid.
    assign in_ready = !valid_reg || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            bundle_reg <= '0;
        end else if (bus.flush) begin
            valid_reg <= 1'b0;
            if (RST_NOP) begin
                bundle_reg <= '0;
            end
        end else if (in_ready) begin
            // Covers empty-accept, consume-only and consume+accept in one step.
            valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                bundle_reg <= bundle_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_reg;
    assign bus.alu_op    = bundle_reg.op;
    assign bus.alu_a     = bundle_reg.a;
    assign bus.alu_b     = bundle_reg.b;
    assign bus.dest      = bundle_reg.dest;
    assign bus.reg_write = bundle_reg.reg_write;
    assign bus.illegal   = bundle_reg.illegal;

endmodule
